// File: rtl/mul_div_unit_pkg.sv
// Shared opcode and state encodings for the ALU control block and the mul/div unit.
package mul_div_unit_pkg;

  localparam logic [5:0] SLL   = 6'b000000;
  localparam logic [5:0] SRL   = 6'b000010;
  localparam logic [5:0] SRA   = 6'b000011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] ADDU  = 6'b100001;
  localparam logic [5:0] SUBU  = 6'b100011;
  localparam logic [5:0] SLTU  = 6'b101011;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DIV  = 2'd2;
  localparam state_t S_DONE = 2'd3;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the datapath and the mul/div unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       op;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, dataA, dataB,
    input  busy, done, div_zero, result
  );

  modport slave (
    input  start, op, dataA, dataB,
    output busy, done, div_zero, result
  );
endinterface

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remainder_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remainder_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // remainder_in < divisor, so a borrow always lands in trial[WIDTH]
  always_comb begin
    shifted       = {remainder_in, dividend_bit};
    trial         = shifted - {1'b0, divisor};
    q_bit         = ~trial[WIDTH];
    remainder_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned MULTU/DIVU unit with HI/LO registers read back through MFHI/MFLO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst_n,
  mul_div_unit_if.slave bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               div_zero_r;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   rem_out;
  logic               q_bit;
  logic               last_iter;

  // Divide reuses prod: upper half is the remainder, lower half shifts dividend out and quotient in
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .remainder_in  (prod[2*WIDTH-1:WIDTH]),
    .dividend_bit  (prod[WIDTH-1]),
    .divisor       (operand),
    .remainder_out (rem_out),
    .q_bit         (q_bit)
  );

  always_comb begin
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    mul_next  = prod[0] ? {sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
    div_next  = {rem_out, prod[WIDTH-2:0], q_bit};
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      prod       <= '0;
      operand    <= '0;
      hi         <= '0;
      lo         <= '0;
      div_zero_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && bus.op == MULTU) begin
            operand    <= bus.dataA;
            prod       <= {{WIDTH{1'b0}}, bus.dataB};
            cnt        <= '0;
            div_zero_r <= 1'b0;
            state      <= S_MUL;
          end else if (bus.start && bus.op == DIVU) begin
            cnt        <= '0;
            div_zero_r <= (bus.dataB == '0);
            if (bus.dataB == '0) begin
              prod  <= {bus.dataA, {WIDTH{1'b1}}};
              state <= S_DONE;
            end else begin
              operand <= bus.dataB;
              prod    <= {{WIDTH{1'b0}}, bus.dataA};
              state   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          prod <= mul_next;
          cnt  <= cnt + CNT_W'(1);
          if (last_iter) state <= S_DONE;
        end
        S_DIV: begin
          prod <= div_next;
          cnt  <= cnt + CNT_W'(1);
          if (last_iter) state <= S_DONE;
        end
        S_DONE: begin
          hi    <= prod[2*WIDTH-1:WIDTH];
          lo    <= prod[WIDTH-1:0];
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_MUL) || (state == S_DIV);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = div_zero_r;

  always_comb begin
    bus.result = '0;
    if (bus.op == MFHI)      bus.result = hi;
    else if (bus.op == MFLO) bus.result = lo;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized ops against an arithmetic model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair
  task automatic model(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (o == MULTU) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      exp_hi = p[2*W-1:W];
      exp_lo = p[W-1:0];
      exp_dz = 1'b0;
    end else if (o == DIVU) begin
      if (b == 0) begin
        exp_hi = a;
        exp_lo = '1;
        exp_dz = 1'b1;
      end else begin
        exp_hi = a % b;
        exp_lo = a / b;
        exp_dz = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.dataA = a; bus.dataB = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 6'b000000;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
    bus.op = MFHI; #1 h = bus.result;
    bus.op = MFLO; #1 l = bus.result;
    bus.op = 6'b000000; #1;
  endtask

  task automatic run_op(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic busy1, output logic done_after,
                        output logic dz, output logic [W-1:0] h, output logic [W-1:0] l);
    issue(o, a, b);
    busy1 = bus.busy;
    wait_done(lat);
    @(negedge clk);
    done_after = bus.done;
    dz = bus.div_zero;
    read_hilo(h, l);
  endtask

  task automatic test_reset;
    logic [W-1:0] h, l;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    n_cmp++; if (bus.div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_div_zero got=%b want=0", bus.div_zero); end
    read_hilo(h, l);
    n_cmp++; if (h !== 32'h0) begin n_bad++; $display("FAIL reset_hi got=%h want=0", h); end
    n_cmp++; if (l !== 32'h0) begin n_bad++; $display("FAIL reset_lo got=%h want=0", l); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_directed;
    int lat; logic b1, da, dz; logic [W-1:0] h, l;

    run_op(MULTU, 32'd7, 32'd6, lat, b1, da, dz, h, l);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mul7x6_latency got=%0d want=33", lat); end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL mul7x6_busy got=%b want=1", b1); end
    n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL mul7x6_done_width got=%b want=0", da); end
    n_cmp++; if (h !== 32'd0) begin n_bad++; $display("FAIL mul7x6_hi got=%h want=0", h); end
    n_cmp++; if (l !== 32'd42) begin n_bad++; $display("FAIL mul7x6_lo got=%h want=2a", l); end

    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, b1, da, dz, h, l);
    n_cmp++; if (h !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL mulmax_hi got=%h want=fffffffe", h); end
    n_cmp++; if (l !== 32'h00000001) begin n_bad++; $display("FAIL mulmax_lo got=%h want=00000001", l); end

    run_op(DIVU, 32'd100, 32'd7, lat, b1, da, dz, h, l);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div100_7_latency got=%0d want=33", lat); end
    n_cmp++; if (h !== 32'd2) begin n_bad++; $display("FAIL div100_7_hi got=%h want=2", h); end
    n_cmp++; if (l !== 32'd14) begin n_bad++; $display("FAIL div100_7_lo got=%h want=e", l); end

    run_op(DIVU, 32'd5, 32'd0, lat, b1, da, dz, h, l);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL div0_latency got=%0d want=1", lat); end
    n_cmp++; if (b1 !== 1'b0) begin n_bad++; $display("FAIL div0_busy got=%b want=0", b1); end
    n_cmp++; if (dz !== 1'b1) begin n_bad++; $display("FAIL div0_flag got=%b want=1", dz); end
    n_cmp++; if (h !== 32'd5) begin n_bad++; $display("FAIL div0_hi got=%h want=5", h); end
    n_cmp++; if (l !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div0_lo got=%h want=ffffffff", l); end
    @(negedge clk);
    n_cmp++; if (bus.div_zero !== 1'b1) begin n_bad++; $display("FAIL div0_sticky got=%b want=1", bus.div_zero); end

    run_op(MULTU, 32'd3, 32'd3, lat, b1, da, dz, h, l);
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL div0_clear got=%b want=0", dz); end
    n_cmp++; if (l !== 32'd9) begin n_bad++; $display("FAIL mul3x3_lo got=%h want=9", l); end
  endtask

  task automatic test_busy_ignore;
    int lat; logic b1, da, dz; logic [W-1:0] h, l;
    run_op(MULTU, 32'd3, 32'd5, lat, b1, da, dz, h, l);
    n_cmp++; if (l !== 32'd15) begin n_bad++; $display("FAIL pre_lo got=%h want=f", l); end
    issue(MULTU, 32'd7, 32'd6);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 5) begin
        bus.op = MFLO; #1;
        n_cmp++; if (bus.result !== 32'd15) begin n_bad++; $display("FAIL mflo_while_busy got=%h want=f", bus.result); end
        bus.op = 6'b000000;
      end
      if (k == 10) begin bus.start = 1'b1; bus.op = MULTU; bus.dataA = 32'd2; bus.dataB = 32'd2; end
      if (k == 11) begin bus.start = 1'b0; bus.op = 6'b000000; end
      if (bus.done) begin lat = k; break; end
      @(negedge clk);
    end
    bus.start = 1'b1; bus.op = MULTU; bus.dataA = 32'd9; bus.dataB = 32'd9;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 6'b000000;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL start_in_done_ignored busy=%b want=0", bus.busy); end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL ignore_latency got=%0d want=33", lat); end
    read_hilo(h, l);
    n_cmp++; if (l !== 32'd42) begin n_bad++; $display("FAIL ignore_lo got=%h want=2a", l); end
    n_cmp++; if (h !== 32'd0) begin n_bad++; $display("FAIL ignore_hi got=%h want=0", h); end
    model(MULTU, 32'd7, 32'd6);
  endtask

  task automatic test_random;
    int lat, want_lat; logic b1, da, dz; logic [W-1:0] h, l, a, b; logic [5:0] o;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      o = ($urandom_range(0, 1) == 0) ? MULTU : DIVU;
      if (o == DIVU && $urandom_range(0, 4) == 0) b = '0;
      else if (o == DIVU && b == 0) b = 32'd1;
      model(o, a, b);
      want_lat = (o == DIVU && b == 0) ? 1 : 33;
      run_op(o, a, b, lat, b1, da, dz, h, l);
      n_cmp++; if (lat !== want_lat) begin n_bad++; $display("FAIL rnd%0d_latency op=%b a=%h b=%h got=%0d want=%0d", i, o, a, b, lat, want_lat); end
      n_cmp++; if (b1 !== (want_lat == 33)) begin n_bad++; $display("FAIL rnd%0d_busy got=%b", i, b1); end
      n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_done_width got=%b want=0", i, da); end
      n_cmp++; if (dz !== exp_dz) begin n_bad++; $display("FAIL rnd%0d_div_zero got=%b want=%b", i, dz, exp_dz); end
      n_cmp++; if (h !== exp_hi) begin n_bad++; $display("FAIL rnd%0d_hi op=%b a=%h b=%h got=%h want=%h", i, o, a, b, h, exp_hi); end
      n_cmp++; if (l !== exp_lo) begin n_bad++; $display("FAIL rnd%0d_lo op=%b a=%h b=%h got=%h want=%h", i, o, a, b, l, exp_lo); end
    end
  endtask

  task automatic test_unknown_op;
    logic [W-1:0] h, l;
    issue(6'b100000, 32'd123, 32'd45);
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL unknown_op_cycle%0d busy=%b done=%b want=0/0", k, bus.busy, bus.done); end
      @(negedge clk);
    end
    read_hilo(h, l);
    n_cmp++; if (h !== exp_hi) begin n_bad++; $display("FAIL unknown_op_hi got=%h want=%h", h, exp_hi); end
    n_cmp++; if (l !== exp_lo) begin n_bad++; $display("FAIL unknown_op_lo got=%h want=%h", l, exp_lo); end
  endtask

  task automatic test_reset_mid;
    int lat; logic b1, da, dz; logic [W-1:0] h, l;
    issue(DIVU, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got=%b want=0", bus.busy); end
    read_hilo(h, l);
    n_cmp++; if (h !== 32'd0) begin n_bad++; $display("FAIL midreset_hi got=%h want=0", h); end
    n_cmp++; if (l !== 32'd0) begin n_bad++; $display("FAIL midreset_lo got=%h want=0", l); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_aborted done=%b busy=%b want=0/0", bus.done, bus.busy); end
    run_op(DIVU, 32'd9, 32'd2, lat, b1, da, dz, h, l);
    n_cmp++; if (h !== 32'd1) begin n_bad++; $display("FAIL div9_2_hi got=%h want=1", h); end
    n_cmp++; if (l !== 32'd4) begin n_bad++; $display("FAIL div9_2_lo got=%h want=4", l); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 6'b000000; bus.dataA = '0; bus.dataB = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_directed;
    test_busy_ignore;
    test_random;
    test_unknown_op;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
